// File: rtl/rx_ctrl_module.sv
`default_nettype none
// ============================================================================
// Module   : rx_ctrl_module
// Brief    : UART receive controller driven by an external mid-bit strobe.
//            Optional even-parity bit enabled by macro RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rx_ctrl_module #(
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 Frame_Err,
  output logic                 Parity_Err
);

  localparam logic [3:0] C_LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_count;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic                 w_line;
  logic                 w_h2l;

  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_ferr;
  logic                 w_par_ok;

  // Two flops for metastability, third flop holds the previous sample for edge detect
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= RX_Pin_In;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_line = r_sync2;
  assign w_h2l  = r_sync3 & ~r_sync2;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_h2l && RX_En_Sig) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_count = 1'b1;
        if (BPS_CLK) begin
          w_state_nxt = w_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_count = 1'b1;
        if (BPS_CLK && (r_bit_idx == C_LAST_IDX)) begin
`ifdef RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        w_count = 1'b1;
        if (BPS_CLK) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_count = 1'b1;
        if (BPS_CLK) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef RX_PARITY_EN
  logic r_par_bit;
  logic r_perr;

  // Even parity: data bits plus parity bit must XOR to zero
  assign w_par_ok   = ~((^r_shift) ^ r_par_bit);
  assign Parity_Err = r_perr;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      if ((r_state == S_PARITY) && BPS_CLK) begin
        r_par_bit <= w_line;
      end
      if ((r_state == S_STOP) && BPS_CLK) begin
        r_perr <= ~w_par_ok;
      end
    end
  end
`else
  assign w_par_ok   = 1'b1;
  assign Parity_Err = 1'b0;
`endif

  // Results are registered on the stop-bit strobe so they are visible during DONE
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shift   <= '0;
      r_bit_idx <= 4'd0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      if ((r_state == S_START) && BPS_CLK) begin
        r_bit_idx <= 4'd0;
      end
      if ((r_state == S_DATA) && BPS_CLK) begin
        r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if ((r_state == S_STOP) && BPS_CLK) begin
        r_ferr <= ~w_line;
        if (w_line && w_par_ok) begin
          r_data <= r_shift;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign Count_Sig   = w_count;
  assign RX_Data     = r_data;
  assign RX_Done_Sig = r_done;
  assign Frame_Err   = r_ferr;

endmodule
`default_nettype wire

// File: doc/rx_ctrl_module.md
RX_CTRL_MODULE -- requirements
Module: rx_ctrl_module

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame (legal 5..8), LSB first.
REQ-002 Port: CLK  input  1  system clock, 50 MHz.
REQ-003 Port: RSTn  input  1  asynchronous active-low reset.
REQ-004 Port: RX_Pin_In  input  1  raw serial line; idle high; asynchronous to CLK.
REQ-005 Port: RX_En_Sig  input  1  receive enable; gates frame start only.
REQ-006 Port: BPS_CLK  input  1  one-cycle mid-bit sample strobe from the companion baud generator.
REQ-007 Port: Count_Sig  output  1  run request to the baud generator; its counter runs while high and clears while low.
REQ-008 Port: RX_Data  output  DATA_BITS  last received data word.
REQ-009 Port: RX_Done_Sig  output  1  one-cycle pulse; RX_Data valid in the same cycle.
REQ-010 Port: Frame_Err  output  1  one-cycle pulse on bad stop bit.
REQ-011 Port: Parity_Err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-012 Synchronisation: RX_Pin_In passes through a 2-flop synchroniser, then a third flop for edge detect; H2L = previous 1 and current 0.
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP, DONE.
REQ-014 IDLE: H2L with RX_En_Sig=1 -> START next cycle; H2L with RX_En_Sig=0 is ignored.
REQ-015 Count_Sig: 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE, so the baud counter always clears between frames.
REQ-016 START: on BPS_CLK, synchronised line 0 -> DATA, bit index 0.
REQ-017 START false-start: on BPS_CLK, line 1 -> IDLE; no output pulse.
REQ-018 DATA: each BPS_CLK shifts the line into the shift register LSB first and increments the bit index.
REQ-019 DATA exit: after DATA_BITS strobes -> PARITY if compiled in, else STOP.
REQ-020 STOP: on BPS_CLK, latch the stop sample, then go to DONE.
REQ-021 DONE lasts exactly one cycle, then returns to IDLE.
REQ-022 DONE, stop sample 1: RX_Data <= shift register and RX_Done_Sig=1.
REQ-023 DONE, stop sample 0: Frame_Err=1, RX_Data unchanged, RX_Done_Sig=0.
REQ-024 RX_Data holds its value until the next good frame.
REQ-025 BPS_CLK is ignored in IDLE and DONE.
REQ-026 Deasserting RX_En_Sig mid-frame has no effect; the frame completes.
REQ-027 A line low in DONE or at IDLE entry starts a new frame only via a fresh H2L edge.
REQ-028 Latency: Count_Sig rises 1 cycle after the H2L detect cycle.
REQ-029 Latency: RX_Done_Sig rises 1 cycle after the stop-bit BPS_CLK.

Reset
REQ-030 On RSTn low, immediately and asynchronously: state IDLE; Count_Sig, RX_Done_Sig, Frame_Err and Parity_Err 0; RX_Data and shift register 0; bit index 0; synchroniser and edge flops 1.
REQ-031 Reset mid-frame abandons the frame with no pulse; the first frame after release needs a new H2L edge.

Configuration
REQ-032 Macro RX_PARITY_EN defined: the PARITY state samples one even-parity bit on BPS_CLK, then goes to STOP.
REQ-033 With RX_PARITY_EN, a parity mismatch pulses Parity_Err in DONE and suppresses RX_Done_Sig and the RX_Data update; a frame error takes precedence and both may pulse together.
REQ-034 Macro RX_PARITY_EN undefined: no PARITY state or logic; Parity_Err is tied to 0.

Verification (50 MHz, 5208 cycles/bit, BPS_CLK at count 2604)
REQ-035 Send 0x55 with a good stop bit -> RX_Done_Sig one pulse, RX_Data=0x55, Count_Sig low in DONE.
REQ-036 Send 0xA3 with stop bit 0 -> Frame_Err one pulse, RX_Done_Sig 0, RX_Data keeps 0x55.
REQ-037 Send a 1000-cycle low glitch from idle -> false start, return to IDLE, Count_Sig falls after the first BPS_CLK, no pulses.
REQ-038 Send 0x3C and 0xC3 back-to-back with RX_En_Sig dropped mid-first frame -> first completes (0x3C); second is ignored if RX_En_Sig is still 0 at its start edge.
REQ-039 Assert RSTn low during bit 4 of 0xFF -> all outputs 0 at once, no pulse; next frame 0x12 -> RX_Data=0x12.
REQ-040 With RX_PARITY_EN, send 0x07 with parity bit 0 -> Parity_Err pulse, no RX_Done_Sig; with parity bit 1 -> RX_Done_Sig, RX_Data=0x07.
